inst_encoder: RTL and testbench

- Encodes LEGv8 instructions, described as kind plus fields, into 32-bit machine words and writes them into instruction memory.
- It is the write-side counterpart of the instruction decoder, used by the test/boot loader to fill imem before the core runs.
- Input uses a valid/ready handshake. Output is an imem write port with back-pressure.
- A FIFO sits between the encode logic and the imem write port.

---
 rtl/inst_encoder_pkg.sv | 47 ++++
 rtl/inst_encoder_fifo.sv | 58 +++++
 rtl/inst_encoder.sv | 185 ++++++++++++++++++
 tb/tb_inst_encoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: shared constants for the LEGv8 instruction encoder.
// Holds the 4-bit request kind codes, the opcode literals for each format,
// the immediate range limits used by the optional range check, and the
// load-controller state type.
package inst_encoder_pkg;

  // Request kind codes (12..15 are illegal)
  localparam logic [3:0] KIND_NOP  = 4'd0;
  localparam logic [3:0] KIND_ADD  = 4'd1;
  localparam logic [3:0] KIND_SUB  = 4'd2;
  localparam logic [3:0] KIND_AND  = 4'd3;
  localparam logic [3:0] KIND_ORR  = 4'd4;
  localparam logic [3:0] KIND_ADDI = 4'd5;
  localparam logic [3:0] KIND_SUBI = 4'd6;
  localparam logic [3:0] KIND_LDUR = 4'd7;
  localparam logic [3:0] KIND_STUR = 4'd8;
  localparam logic [3:0] KIND_CBZ  = 4'd9;
  localparam logic [3:0] KIND_CBNZ = 4'd10;
  localparam logic [3:0] KIND_B    = 4'd11;

  // Opcode literals
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // Immediate range limits (26-bit view of in_imm)
  localparam logic        [25:0] IMM12_MAX  = 26'd4095;
  localparam logic signed [25:0] D_IMM_MIN  = -26'sd256;
  localparam logic signed [25:0] D_IMM_MAX  = 26'sd255;
  localparam logic signed [25:0] CB_IMM_MIN = -26'sd262144;
  localparam logic signed [25:0] CB_IMM_MAX = 26'sd262143;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/inst_encoder_fifo.sv
// enc_word_fifo: synchronous FIFO for encoded instruction words.
// Ports: clk, rst (async, active-high), flush (sync discard of contents),
//        push/push_data, pop/pop_data (head word, zero when empty),
//        full, empty.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module enc_word_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Zero when empty so the write port idles at a known value after reset
  assign pop_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      if (do_push && !do_pop)      cnt <= cnt + CNT_ONE;
      else if (!do_push && do_pop) cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: encodes LEGv8 instruction requests (kind + fields) into
// 32-bit words and writes them to instruction memory through a word FIFO.
// Ports:
//   clk, rst (async, active-high)
//   cfg_load/cfg_base_addr   start a program load at a byte address
//   in_valid/in_ready/in_last, in_kind, in_rd, in_rn, in_rm, in_imm
//                            request handshake and instruction fields
//   imem_we/imem_ready, imem_addr, imem_wdata
//                            imem write port with back-pressure
//   busy, done, word_count, err_illegal   status
// Optional: define INST_ENCODER_RANGE_CHECK_EN to add err_range and drop
// requests whose immediate does not fit its field; otherwise immediates are
// truncated to the field width.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       word_count,
  output logic              err_illegal
`ifdef INST_ENCODER_RANGE_CHECK_EN
  ,
  output logic              err_range
`endif
);

  function automatic logic [31:0] encode_word(input logic [3:0] kind,
                                              input logic [4:0] rd,
                                              input logic [4:0] rn,
                                              input logic [4:0] rm,
                                              input logic [25:0] imm);
    logic [31:0] w;
    w = '0;
    case (kind)
      KIND_ADD:  w = {OP_ADD, rm, 6'b0, rn, rd};
      KIND_SUB:  w = {OP_SUB, rm, 6'b0, rn, rd};
      KIND_AND:  w = {OP_AND, rm, 6'b0, rn, rd};
      KIND_ORR:  w = {OP_ORR, rm, 6'b0, rn, rd};
      KIND_ADDI: w = {OP_ADDI, imm[11:0], rn, rd};
      KIND_SUBI: w = {OP_SUBI, imm[11:0], rn, rd};
      KIND_LDUR: w = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
      KIND_STUR: w = {OP_STUR, imm[8:0], 2'b00, rn, rd};
      KIND_CBZ:  w = {OP_CBZ, imm[18:0], rd};
      KIND_CBNZ: w = {OP_CBNZ, imm[18:0], rd};
      KIND_B:    w = {OP_B, imm};
      default:   w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef INST_ENCODER_RANGE_CHECK_EN
  function automatic logic imm_in_range(input logic [3:0] kind,
                                        input logic [25:0] imm);
    logic signed [25:0] imm_s;
    logic               ok;
    imm_s = imm;
    ok    = 1'b1;
    case (kind)
      KIND_ADDI, KIND_SUBI: ok = (imm <= IMM12_MAX);
      KIND_LDUR, KIND_STUR: ok = (imm_s >= D_IMM_MIN) && (imm_s <= D_IMM_MAX);
      KIND_CBZ, KIND_CBNZ:  ok = (imm_s >= CB_IMM_MIN) && (imm_s <= CB_IMM_MAX);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  state_e      state_q, state_d;
  logic        accept, legal, keep;
  logic        vld_p0;
  logic [31:0] enc_word_p0;
  logic        fifo_full, fifo_empty, fifo_pop;

  // Stage p0: combinational encode, pushed into the FIFO on acceptance
  assign accept      = in_valid && in_ready;
  assign legal       = (in_kind <= KIND_B);
  assign enc_word_p0 = encode_word(in_kind, in_rd, in_rn, in_rm, in_imm);
`ifdef INST_ENCODER_RANGE_CHECK_EN
  assign keep = legal && imm_in_range(in_kind, in_imm);
`else
  assign keep = legal;
`endif
  assign vld_p0 = accept && keep;

  // Stage p1: FIFO head drives the imem write port
  enc_word_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (cfg_load),
    .push      (vld_p0),
    .push_data (enc_word_p0),
    .pop       (fifo_pop),
    .pop_data  (imem_wdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_we  = !fifo_empty;
  assign fifo_pop = imem_we && imem_ready;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = !fifo_full;
        if (in_valid && in_ready && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // FIFO empty means imem_we is low, so no write is outstanding
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    // A new load restarts from any state and blocks requests for that cycle
    if (cfg_load) begin
      in_ready = 1'b0;
      done     = 1'b0;
      state_d  = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr   <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else if (cfg_load) begin
      imem_addr   <= cfg_base_addr;
      word_count  <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (fifo_pop) begin
        imem_addr  <= imem_addr + ADDR_W'(4);
        word_count <= sat_inc16(word_count);
      end
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_range <= 1'b0;
    else if (cfg_load)                       err_range <= 1'b0;
    else if (accept && legal && !keep)       err_range <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed bench for inst_encoder. A table of single
// instructions with hand-computed words is streamed as one program, plus
// hand-written sequences for back-pressure, illegal kinds, the ADDI range
// case and reset during a load. Inputs change 1 time unit after the rising
// edge; outputs and imem writes are sampled on the falling edge.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
  logic [25:0] in_imm = '0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done;
  logic [15:0] word_count;
  logic        err_illegal;
`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic        err_range;
`endif

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_load      (cfg_load),
    .cfg_base_addr (cfg_base_addr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_kind       (in_kind),
    .in_rd         (in_rd),
    .in_rn         (in_rn),
    .in_rm         (in_rm),
    .in_imm        (in_imm),
    .imem_we       (imem_we),
    .imem_ready    (imem_ready),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .busy          (busy),
    .done          (done),
    .word_count    (word_count),
    .err_illegal   (err_illegal)
`ifdef INST_ENCODER_RANGE_CHECK_EN
    ,
    .err_range     (err_range)
`endif
  );

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [12];
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  // Record every completed imem write
  always @(negedge clk) begin
    if (!rst && imem_we && imem_ready) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [31:0] exp_addr,
                        input logic [31:0] exp_data);
    if (idx >= wr_data_q.size()) begin
      total++;
      bad++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, idx, wr_data_q.size());
    end else begin
      chk({nm, "_addr"}, wr_addr_q[idx], exp_addr);
      chk({nm, "_data"}, wr_data_q[idx], exp_data);
    end
  endtask

  task automatic do_load(input logic [31:0] base);
    wr_addr_q.delete();
    wr_data_q.delete();
    acc_cnt       = 0;
    cfg_load      = 1'b1;
    cfg_base_addr = base;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [3:0] kind, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [25:0] imm, input logic last);
    bit ok = 0;
    in_kind = kind; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) acc_cnt++;
    else begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    @(posedge clk); #1;
    chk({nm, "_done"}, {31'b0, seen}, 32'd1);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] hold_addr, hold_data;

  initial begin
    tbl[0]  = '{KIND_SUB,  5'd0,  5'd0,  5'd0,  26'd0,        32'hCB000000};
    tbl[1]  = '{KIND_AND,  5'd0,  5'd0,  5'd0,  26'd0,        32'h8A000000};
    tbl[2]  = '{KIND_ORR,  5'd31, 5'd31, 5'd31, 26'd0,        32'hAA1F03FF};
    tbl[3]  = '{KIND_SUBI, 5'd2,  5'd3,  5'd0,  26'd5,        32'hD1001462};
    tbl[4]  = '{KIND_STUR, 5'd1,  5'd2,  5'd0,  26'h3FFFFFF,  32'hF81FF041};
    tbl[5]  = '{KIND_CBNZ, 5'd0,  5'd0,  5'd0,  26'd1,        32'hB5000020};
    tbl[6]  = '{KIND_NOP,  5'd9,  5'd9,  5'd9,  26'h155,      32'h00000000};
    tbl[7]  = '{KIND_B,    5'd0,  5'd0,  5'd0,  26'h3FFFFFF,  32'h17FFFFFF};
    tbl[8]  = '{KIND_ADDI, 5'd1,  5'd2,  5'd0,  26'd4095,     32'h913FFC41};
    tbl[9]  = '{KIND_LDUR, 5'd31, 5'd31, 5'd0,  26'h3FFFF00,  32'hF85003FF};
    tbl[10] = '{KIND_CBZ,  5'd3,  5'd0,  5'd0,  26'h3FC0000,  32'hB4800003};
    tbl[11] = '{KIND_ADD,  5'd4,  5'd5,  5'd6,  26'h3FFFFFF,  32'h8B0600A4};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_word_count", {16'b0, word_count}, 32'd0);
    chk("rst_err_illegal", {31'b0, err_illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single ADD
    do_load(32'h100);
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1);
    wait_done("add");
    chk("add_nwr", wr_data_q.size(), 32'd1);
    chk_wr("add_w0", 0, 32'h100, 32'h8B020023);
    chk("add_wc", {16'b0, word_count}, 32'd1);

    // LDUR, CBZ, B
    do_load(32'h100);
    send(KIND_LDUR, 5'd5, 5'd2, 5'd0, 26'd8, 1'b0);
    send(KIND_CBZ, 5'd7, 5'd0, 5'd0, 26'h3FFFFFE, 1'b0);
    send(KIND_B, 5'd0, 5'd0, 5'd0, 26'd3, 1'b1);
    wait_done("seq3");
    chk("seq3_nwr", wr_data_q.size(), 32'd3);
    chk_wr("seq3_w0", 0, 32'h100, 32'hF8408045);
    chk_wr("seq3_w1", 1, 32'h104, 32'hB4FFFFC7);
    chk_wr("seq3_w2", 2, 32'h108, 32'h14000003);
    chk("seq3_wc", {16'b0, word_count}, 32'd3);

    // Table sweep as one program
    do_load(32'h200);
    for (int i = 0; i < 12; i++)
      send(tbl[i].kind, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, i == 11);
    wait_done("tbl");
    chk("tbl_nwr", wr_data_q.size(), 32'd12);
    for (int i = 0; i < 12; i++)
      chk_wr($sformatf("tbl%0d", i), i, 32'h200 + 32'(4 * i), tbl[i].exp);
    chk("tbl_wc", {16'b0, word_count}, 32'd12);
    chk("tbl_err_illegal", {31'b0, err_illegal}, 32'd0);

    // Back-pressure: 6 requests with imem_ready low
    imem_ready = 1'b0;
    do_load(32'h300);
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(KIND_ADD, 5'(i), 5'd0, 5'd0, 26'd0, i == 5);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", acc_cnt, 32'd4);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_we", {31'b0, imem_we}, 32'd1);
        chk("bp_addr", imem_addr, 32'h300);
        chk("bp_data", imem_wdata, 32'h8B000000);
        hold_addr = imem_addr;
        hold_data = imem_wdata;
        repeat (5) @(negedge clk);
        chk("bp_addr_hold", imem_addr, hold_addr);
        chk("bp_data_hold", imem_wdata, hold_data);
        @(posedge clk); #1;
        imem_ready = 1'b1;
      end
    join
    wait_done("bp");
    chk("bp_nwr", wr_data_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk_wr($sformatf("bp%0d", i), i, 32'h300 + 32'(4 * i), 32'h8B000000 | 32'(i));

    // Illegal kind mid-stream
    do_load(32'h400);
    send(KIND_ADD, 5'd1, 5'd0, 5'd0, 26'd0, 1'b0);
    send(4'd13, 5'd2, 5'd0, 5'd0, 26'd0, 1'b0);
    send(KIND_ADD, 5'd2, 5'd0, 5'd0, 26'd0, 1'b1);
    wait_done("ill");
    chk("ill_err", {31'b0, err_illegal}, 32'd1);
    chk("ill_nwr", wr_data_q.size(), 32'd2);
    chk_wr("ill_w0", 0, 32'h400, 32'h8B000001);
    chk_wr("ill_w1", 1, 32'h404, 32'h8B000002);

    // ADDI with an immediate one past the 12-bit field
    do_load(32'h500);
    chk("ill_err_cleared", {31'b0, err_illegal}, 32'd0);
    send(KIND_ADDI, 5'd1, 5'd1, 5'd0, 26'd4096, 1'b1);
    wait_done("addi");
`ifdef INST_ENCODER_RANGE_CHECK_EN
    chk("addi_err_range", {31'b0, err_range}, 32'd1);
    chk("addi_nwr", wr_data_q.size(), 32'd0);
`else
    chk("addi_nwr", wr_data_q.size(), 32'd1);
    chk_wr("addi_w0", 0, 32'h500, 32'h91000021);
`endif

    // Reset while three words are buffered
    imem_ready = 1'b0;
    do_load(32'h600);
    for (int i = 0; i < 3; i++)
      send(KIND_SUB, 5'(i + 1), 5'd0, 5'd0, 26'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_we", {31'b0, imem_we}, 32'd0);
    chk("mrst_addr", imem_addr, 32'd0);
    chk("mrst_wdata", imem_wdata, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mrst_wc", {16'b0, word_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    do_load(32'h700);
    send(KIND_ADD, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1);
    wait_done("rl");
    chk("rl_nwr", wr_data_q.size(), 32'd1);
    chk_wr("rl_w0", 0, 32'h700, 32'h8B020023);
    chk("rl_wc", {16'b0, word_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
